// File: rtl/wb_pkg.sv
// Shared bus definitions: initiator state encoding and default bus dimensions.
package wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_TURN = 2'd2
    } wb_state_e;

    localparam int WB_DATA_WIDTH_DEF = 8;
    localparam int WB_ADDR_WIDTH_DEF = 16;
    localparam int WB_TIMEOUT_DEF    = 16;

endpackage

// File: rtl/wb_master.sv
// Single-outstanding Wishbone classic initiator bridging a host req/resp
// handshake onto strobe/ack cycles, with a bounded ack timeout.
//
// state | meaning
// IDLE  | ready for a host request, bus quiet
// BUS   | strobe asserted, waiting for ack or timeout
// TURN  | one dead cycle that swallows a slave's lingering registered ack
module wb_master
    import wb_pkg::*;
#(
    parameter int WB_DATA_WIDTH = WB_DATA_WIDTH_DEF,
    parameter int WB_ADDR_WIDTH = WB_ADDR_WIDTH_DEF,
    parameter int TIMEOUT       = WB_TIMEOUT_DEF
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     req_i,
    input  logic                     req_we_i,
    input  logic [WB_ADDR_WIDTH-1:0] req_adr_i,
    input  logic [WB_DATA_WIDTH-1:0] req_dat_i,
    output logic                     ready_o,
    output logic                     resp_valid_o,
    output logic [WB_DATA_WIDTH-1:0] resp_dat_o,
    output logic                     resp_err_o,
    output logic                     stb_o,
    output logic                     we_o,
    output logic [WB_ADDR_WIDTH-1:0] adr_o,
    output logic [WB_DATA_WIDTH-1:0] dat_o,
    input  logic [WB_DATA_WIDTH-1:0] dat_i,
    input  logic                     ack_i
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    wb_state_e                state_q, state_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic                     stb_q, stb_d;
    logic                     we_q, we_d;
    logic [WB_ADDR_WIDTH-1:0] adr_q, adr_d;
    logic [WB_DATA_WIDTH-1:0] dat_q, dat_d;
    logic                     resp_valid_q, resp_valid_d;
    logic                     resp_err_q, resp_err_d;
    logic [WB_DATA_WIDTH-1:0] resp_dat_q, resp_dat_d;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            stb_q        <= 1'b0;
            we_q         <= 1'b0;
            adr_q        <= '0;
            dat_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_dat_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            stb_q        <= stb_d;
            we_q         <= we_d;
            adr_q        <= adr_d;
            dat_q        <= dat_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_dat_q   <= resp_dat_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        stb_d        = stb_q;
        we_d         = we_q;
        adr_d        = adr_q;
        dat_d        = dat_q;
        resp_valid_d = 1'b0;
        resp_err_d   = resp_err_q;
        resp_dat_d   = resp_dat_q;

        unique case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    we_d    = req_we_i;
                    adr_d   = req_adr_i;
                    dat_d   = req_dat_i;
                    cnt_d   = '0;
                    stb_d   = 1'b1;
                    state_d = ST_BUS;
                end
            end
            ST_BUS: begin
                if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
                // ack is checked first so it wins over a coincident timeout
                if (ack_i) begin
                    stb_d        = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    resp_dat_d   = we_q ? '0 : dat_i;
                    state_d      = ST_TURN;
                end else if (cnt_q >= CNT_LAST) begin
                    stb_d        = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                    resp_dat_d   = '0;
                    state_d      = ST_TURN;
                end
            end
            ST_TURN: state_d = ST_IDLE;
            default: begin
                stb_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign ready_o      = (state_q == ST_IDLE);
    assign resp_valid_o = resp_valid_q;
    assign resp_err_o   = resp_err_q;
    assign resp_dat_o   = resp_dat_q;
    assign stb_o        = stb_q;
    assign we_o         = we_q;
    assign adr_o        = adr_q;
    assign dat_o        = dat_q;

endmodule

// File: tb/tb_wb_master.sv
// Directed bench for wb_master: ROM-style slave with registered ack plus a
// manually driven ack path for timeout and reset scenarios.
module tb_wb_master;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        req_i = 1'b0;
    logic        req_we_i = 1'b0;
    logic [15:0] req_adr_i = '0;
    logic [7:0]  req_dat_i = '0;
    logic        ready_o;
    logic        resp_valid_o;
    logic [7:0]  resp_dat_o;
    logic        resp_err_o;
    logic        stb_o;
    logic        we_o;
    logic [15:0] adr_o;
    logic [7:0]  dat_o;
    logic [7:0]  dat_i;
    logic        ack_i;

    logic        slave_rom = 1'b1;
    logic        man_ack = 1'b0;
    logic [7:0]  man_dat = 8'h00;
    logic        rom_ack;
    logic [7:0]  rom_dat;

    int errors = 0;
    int checks = 0;

    wb_master #(.WB_DATA_WIDTH(8), .WB_ADDR_WIDTH(16), .TIMEOUT(16)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .req_i(req_i), .req_we_i(req_we_i), .req_adr_i(req_adr_i), .req_dat_i(req_dat_i),
        .ready_o(ready_o), .resp_valid_o(resp_valid_o), .resp_dat_o(resp_dat_o),
        .resp_err_o(resp_err_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o),
        .dat_o(dat_o), .dat_i(dat_i), .ack_i(ack_i)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [7:0] rom_lookup(input logic [15:0] a);
        case (a)
            16'h0000: rom_lookup = 8'hA9;
            16'h0FFC: rom_lookup = 8'h00;
            16'h0FFD: rom_lookup = 8'hF0;
            default:  rom_lookup = 8'h55;
        endcase
    endfunction

    // ROM slave: ack registered from strobe, so it lingers one cycle after stb drops
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rom_ack <= 1'b0;
            rom_dat <= 8'h00;
        end else begin
            rom_ack <= stb_o;
            rom_dat <= rom_lookup(adr_o);
        end
    end

    assign ack_i = slave_rom ? rom_ack : man_ack;
    assign dat_i = slave_rom ? rom_dat : man_dat;

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        req_i = 1'b1;
        req_adr_i = 16'h0000;
        repeat (3) cyc();
        checks++;
        if (stb_o !== 1'b0) begin errors++; $display("FAIL reset_no_accept: stb_o=%b want 0", stb_o); end
        req_i = 1'b0;
        #3 rst_n_i = 1'b1;
        #1;
        checks++;
        if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: ready_o=%b want 1", ready_o); end
        checks++;
        if ({stb_o, we_o, adr_o, dat_o, resp_valid_o, resp_err_o, resp_dat_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: stb=%b we=%b adr=%h dat=%h rv=%b err=%b rdat=%h want all 0",
                     stb_o, we_o, adr_o, dat_o, resp_valid_o, resp_err_o, resp_dat_o);
        end
        cyc();
        checks++;
        if (stb_o !== 1'b0) begin errors++; $display("FAIL reset_idle_stb: stb_o=%b want 0", stb_o); end
    endtask

    task automatic test_read();
        req_i = 1'b1; req_we_i = 1'b0; req_adr_i = 16'h0000; req_dat_i = 8'h11;
        checks++;
        if (ready_o !== 1'b1) begin errors++; $display("FAIL read_ready_n: ready_o=%b want 1", ready_o); end
        cyc();
        req_i = 1'b0; req_adr_i = 16'hBEEF; req_we_i = 1'b1;
        checks++;
        if ({stb_o, we_o, adr_o, resp_valid_o} !== {1'b1, 1'b0, 16'h0000, 1'b0}) begin
            errors++;
            $display("FAIL read_n1: stb=%b we=%b adr=%h rv=%b want 1 0 0000 0", stb_o, we_o, adr_o, resp_valid_o);
        end
        cyc();
        checks++;
        if ({stb_o, adr_o, resp_valid_o} !== {1'b1, 16'h0000, 1'b0}) begin
            errors++;
            $display("FAIL read_n2: stb=%b adr=%h rv=%b want 1 0000 0", stb_o, adr_o, resp_valid_o);
        end
        cyc();
        checks++;
        if ({resp_valid_o, resp_err_o, resp_dat_o, stb_o, ready_o} !== {1'b1, 1'b0, 8'hA9, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL read_n3: rv=%b err=%b rdat=%h stb=%b ready=%b want 1 0 a9 0 0",
                     resp_valid_o, resp_err_o, resp_dat_o, stb_o, ready_o);
        end
        cyc();
        checks++;
        if ({ready_o, resp_valid_o, resp_dat_o} !== {1'b1, 1'b0, 8'hA9}) begin
            errors++;
            $display("FAIL read_n4: ready=%b rv=%b rdat=%h want 1 0 a9", ready_o, resp_valid_o, resp_dat_o);
        end
        req_we_i = 1'b0;
    endtask

    task automatic test_write();
        req_i = 1'b1; req_we_i = 1'b1; req_adr_i = 16'h0004; req_dat_i = 8'hFF;
        cyc();
        req_i = 1'b0; req_dat_i = 8'h00;
        checks++;
        if ({stb_o, we_o, adr_o, dat_o} !== {1'b1, 1'b1, 16'h0004, 8'hFF}) begin
            errors++;
            $display("FAIL write_bus: stb=%b we=%b adr=%h dat=%h want 1 1 0004 ff", stb_o, we_o, adr_o, dat_o);
        end
        cyc();
        checks++;
        if ({stb_o, we_o, dat_o} !== {1'b1, 1'b1, 8'hFF}) begin
            errors++;
            $display("FAIL write_hold: stb=%b we=%b dat=%h want 1 1 ff", stb_o, we_o, dat_o);
        end
        cyc();
        checks++;
        if ({resp_valid_o, resp_err_o, resp_dat_o} !== {1'b1, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL write_resp: rv=%b err=%b rdat=%h want 1 0 00", resp_valid_o, resp_err_o, resp_dat_o);
        end
        cyc();
        req_we_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        int n_resp = 0;
        int k_first = -1;
        int k_second = -1;
        logic [7:0] d_first = 8'hxx;
        logic [7:0] d_second = 8'hxx;
        req_i = 1'b1; req_we_i = 1'b0; req_adr_i = 16'h0FFC;
        for (int k = 1; k <= 12; k++) begin
            cyc();
            if (k == 1) req_adr_i = 16'h0FFD;
            if (k == 5) req_i = 1'b0;
            if (resp_valid_o) begin
                n_resp++;
                if (n_resp == 1) begin k_first = k; d_first = resp_dat_o; end
                if (n_resp == 2) begin k_second = k; d_second = resp_dat_o; end
            end
        end
        checks++;
        if (n_resp != 2) begin errors++; $display("FAIL b2b_count: responses=%0d want 2", n_resp); end
        checks++;
        if (k_first != 3 || d_first !== 8'h00) begin
            errors++; $display("FAIL b2b_first: cycle=%0d data=%h want 3 00", k_first, d_first);
        end
        checks++;
        if (k_second != 7 || d_second !== 8'hF0) begin
            errors++; $display("FAIL b2b_second: cycle=%0d data=%h want 7 f0", k_second, d_second);
        end
    endtask

    task automatic test_timeout();
        int n_stb = 0;
        int n_resp = 0;
        int k_resp = -1;
        logic err_seen = 1'bx;
        logic [7:0] dat_seen = 8'hxx;
        int k_ready = -1;
        slave_rom = 1'b0; man_ack = 1'b0; man_dat = 8'h77;
        req_i = 1'b1; req_we_i = 1'b0; req_adr_i = 16'h1234;
        for (int k = 1; k <= 30; k++) begin
            cyc();
            if (k == 1) req_i = 1'b0;
            if (stb_o) n_stb++;
            if (resp_valid_o) begin
                n_resp++; k_resp = k; err_seen = resp_err_o; dat_seen = resp_dat_o;
            end
            if (ready_o && k_ready < 0) k_ready = k;
        end
        checks++;
        if (n_stb != 16) begin errors++; $display("FAIL timeout_stb_len: cycles=%0d want 16", n_stb); end
        checks++;
        if (n_resp != 1 || k_resp != 17) begin
            errors++; $display("FAIL timeout_resp: count=%0d cycle=%0d want 1 17", n_resp, k_resp);
        end
        checks++;
        if (err_seen !== 1'b1 || dat_seen !== 8'h00) begin
            errors++; $display("FAIL timeout_err: err=%b data=%h want 1 00", err_seen, dat_seen);
        end
        checks++;
        if (k_ready != 18) begin errors++; $display("FAIL timeout_idle: ready cycle=%0d want 18", k_ready); end
    endtask

    task automatic test_ack_at_timeout();
        slave_rom = 1'b0; man_ack = 1'b0; man_dat = 8'h3C;
        req_i = 1'b1; req_we_i = 1'b0; req_adr_i = 16'h0042;
        for (int k = 1; k <= 16; k++) begin
            cyc();
            if (k == 1) req_i = 1'b0;
        end
        checks++;
        if ({stb_o, resp_valid_o} !== 2'b10) begin
            errors++; $display("FAIL coinc_last_bus: stb=%b rv=%b want 1 0", stb_o, resp_valid_o);
        end
        man_ack = 1'b1;
        cyc();
        checks++;
        if ({resp_valid_o, resp_err_o, resp_dat_o} !== {1'b1, 1'b0, 8'h3C}) begin
            errors++;
            $display("FAIL coinc_resp: rv=%b err=%b rdat=%h want 1 0 3c", resp_valid_o, resp_err_o, resp_dat_o);
        end
        // ack held through TURN and IDLE must be inert
        repeat (3) begin
            cyc();
            checks++;
            if ({resp_valid_o, stb_o} !== 2'b00) begin
                errors++; $display("FAIL stray_ack: rv=%b stb=%b want 0 0", resp_valid_o, stb_o);
            end
        end
        man_ack = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n_resp = 0;
        slave_rom = 1'b0; man_ack = 1'b0; man_dat = 8'h99;
        req_i = 1'b1; req_we_i = 1'b1; req_adr_i = 16'h0ABC; req_dat_i = 8'h5A;
        cyc();
        req_i = 1'b0;
        cyc(); cyc();
        checks++;
        if (stb_o !== 1'b1) begin errors++; $display("FAIL rstmid_pre: stb=%b want 1", stb_o); end
        #2 rst_n_i = 1'b0;
        #1;
        checks++;
        if ({stb_o, we_o, adr_o, dat_o, resp_dat_o} !== '0) begin
            errors++;
            $display("FAIL rstmid_async: stb=%b we=%b adr=%h dat=%h rdat=%h want all 0",
                     stb_o, we_o, adr_o, dat_o, resp_dat_o);
        end
        @(posedge clk_i); @(posedge clk_i);
        #3 rst_n_i = 1'b1;
        #1;
        checks++;
        if (ready_o !== 1'b1) begin errors++; $display("FAIL rstmid_ready: ready=%b want 1", ready_o); end
        slave_rom = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cyc();
            if (resp_valid_o) n_resp++;
        end
        checks++;
        if (n_resp != 0) begin errors++; $display("FAIL rstmid_no_resp: responses=%0d want 0", n_resp); end
        req_i = 1'b1; req_we_i = 1'b0; req_adr_i = 16'h0000;
        cyc();
        req_i = 1'b0;
        cyc(); cyc();
        checks++;
        if ({resp_valid_o, resp_err_o, resp_dat_o} !== {1'b1, 1'b0, 8'hA9}) begin
            errors++;
            $display("FAIL rstmid_next: rv=%b err=%b rdat=%h want 1 0 a9", resp_valid_o, resp_err_o, resp_dat_o);
        end
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_read();
        test_write();
        test_back_to_back();
        test_timeout();
        test_ack_at_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
